// File: rtl/cpld_cfg_ctrl.sv
// cpld_cfg_ctrl: upstream configuration stage of the 1MB RAM expansion CPLD.
// After reset it waits for the board to settle, debounces the DIP switches
// overlaid on ramadrhi[4:3], and then starts driving those lines. Once live it
// decodes Z80 writes to the RAM (&7Fxx, data 11xxxxxx) and ROM (data 10xxxxxx)
// control ports into registered bank-select and ROM-disable state.
//
// Optional build macro: SHADOW_ALIAS_EN
//   defined   - in 1MB mode with the shadow DIP set, a request for the shadow
//               bank is aliased to the bank below it (ramblock[3] cleared).
//   undefined - no aliasing; the shadow bank can be selected directly and the
//               downstream mapping stage resolves the conflict.
module cpld_cfg_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned STABLE_SAMPLES = 3
`ifdef SHADOW_ALIAS_EN
  ,
  parameter logic [3:0]  SHADOW_BANK    = 4'b0111
`endif
) (
  input  logic       clk,
  input  logic       reset_b_w,
  input  logic       iorq_b,
  input  logic       wr_b,
  input  logic       adr15,
  input  logic       adr8,
  input  logic [7:0] data,
  input  logic [1:0] dip_lo,
  input  logic [1:0] dip_hi_in,
  output logic       adr_drive_en,
  output logic       cfg_valid,
  output logic [3:0] dip_cfg,
  output logic [6:0] ramblock,
  output logic       mode3_od,
  output logic       urom_dis,
  output logic       lrom_dis,
  output logic       cfg_wr
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] STABLE_LAST = 4'(STABLE_SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  // Card size as encoded by DIP 3,4 ({d3, d2}).
  typedef enum logic [1:0] {
    SIZE_OFF  = 2'b00,
    SIZE_512K = 2'b01,
    SIZE_64K  = 2'b10,
    SIZE_1MB  = 2'b11
  } size_e;

  // Configuration FSM state
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] sample_q, sample_d;
  logic       sample_vld_q, sample_vld_d;
  logic [3:0] dip_cfg_q, dip_cfg_d;
  logic       drive_q, drive_d;
  logic       cfg_valid_q, cfg_valid_d;

  // I/O write edge detection
  logic       io_wr;
  logic       io_wr_q, io_wr_d;
  logic       io_prev_q, io_prev_d;

  // Control registers fed downstream
  logic [6:0] ramblock_q, ramblock_d;
  logic       mode3_od_q, mode3_od_d;
  logic       urom_dis_q, urom_dis_d;
  logic       lrom_dis_q, lrom_dis_d;
  logic       cfg_wr_q, cfg_wr_d;

  // Derived configuration
  size_e      ram_size;
  logic       overdrive;
  logic       card_off;
  logic       io_action;
  logic       ram_wr;
  logic       rom_wr;
  logic [6:0] ram_req;

  assign ram_size  = size_e'(dip_cfg_q[3:2]);
  assign overdrive = dip_cfg_q[0] | dip_cfg_q[1];
  assign card_off  = (ram_size == SIZE_OFF);

  // Settle, debounce and accept the DIP switches, then hold in RUN until reset.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    sample_d     = sample_q;
    sample_vld_d = sample_vld_q;
    dip_cfg_d    = dip_cfg_q;
    drive_d      = (state_q == ST_RUN);
    cfg_valid_d  = (state_q == ST_RUN);

    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d      = ST_SAMPLE;
          cnt_d        = '0;
          sample_vld_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_SAMPLE: begin
        // The first sample after settling has nothing to compare against, so
        // it only opens a new run of identical samples.
        if (!sample_vld_q || (dip_hi_in != sample_q)) begin
          sample_d     = dip_hi_in;
          sample_vld_d = 1'b1;
          cnt_d        = '0;
          if (STABLE_SAMPLES == 1) begin
            dip_cfg_d = {dip_hi_in, dip_lo};
            state_d   = ST_RUN;
          end
        end else if ((cnt_q + 4'd1) >= STABLE_LAST) begin
          dip_cfg_d = {dip_hi_in, dip_lo};
          state_d   = ST_RUN;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_RUN: begin
        state_d = ST_RUN;
      end

      default: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM and configuration registers.
  always_ff @(posedge clk or negedge reset_b_w) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value regardless of statement order.
    if (!reset_b_w) begin
      state_q      <= ST_SETTLE;
      cnt_q        <= '0;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
      dip_cfg_q    <= '0;
      drive_q      <= 1'b0;
      cfg_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sample_q     <= sample_d;
      sample_vld_q <= sample_vld_d;
      dip_cfg_q    <= dip_cfg_d;
      drive_q      <= drive_d;
      cfg_valid_q  <= cfg_valid_d;
    end
  end

  // Detect the first registered clock of each I/O write cycle; a long IORQ
  // still produces exactly one action.
  always_comb begin
    io_wr     = !iorq_b && !wr_b && !adr15;
    io_wr_d   = io_wr;
    io_prev_d = io_wr_q;
    io_action = io_wr_q && !io_prev_q && (state_q == ST_RUN) && !card_off;
    ram_wr    = io_action && (data[7:6] == 2'b11);
    rom_wr    = io_action && (data[7:6] == 2'b10);
  end

  // Map a RAM-control write onto the bank-select word for the current card size.
  always_comb begin
    ram_req = {adr8, data[5:0]};
    case (ram_size)
      SIZE_64K:  ram_req = {4'b1000, data[2:0]};
      SIZE_512K: ram_req = {1'b1, data[5:0]};
      default: begin
        ram_req = {adr8, data[5:0]};
`ifdef SHADOW_ALIAS_EN
        // Shadow RAM owns SHADOW_BANK; fold requests for it onto the bank below.
        if (dip_cfg_q[0] && ({adr8, data[5:3]} == SHADOW_BANK)) begin
          ram_req[3] = 1'b0;
        end
`endif
      end
    endcase
  end

  // Next values of the RAM/ROM control registers.
  always_comb begin
    ramblock_d = ramblock_q;
    mode3_od_d = mode3_od_q;
    urom_dis_d = urom_dis_q;
    lrom_dis_d = lrom_dis_q;
    cfg_wr_d   = 1'b0;
    if (ram_wr) begin
      ramblock_d = ram_req;
      mode3_od_d = overdrive && (data[2:0] == 3'd3);
      cfg_wr_d   = 1'b1;
    end
    if (rom_wr) begin
      urom_dis_d = data[3];
      lrom_dis_d = data[2];
    end
  end

  // I/O pipeline and control registers.
  always_ff @(posedge clk or negedge reset_b_w) begin
    if (!reset_b_w) begin
      io_wr_q    <= 1'b0;
      io_prev_q  <= 1'b0;
      ramblock_q <= '0;
      mode3_od_q <= 1'b0;
      urom_dis_q <= 1'b0;
      lrom_dis_q <= 1'b0;
      cfg_wr_q   <= 1'b0;
    end else begin
      io_wr_q    <= io_wr_d;
      io_prev_q  <= io_prev_d;
      ramblock_q <= ramblock_d;
      mode3_od_q <= mode3_od_d;
      urom_dis_q <= urom_dis_d;
      lrom_dis_q <= lrom_dis_d;
      cfg_wr_q   <= cfg_wr_d;
    end
  end

  // The drivers are gated by reset directly so ramadrhi floats the moment
  // reset asserts, without waiting for the flop to clear.
  assign adr_drive_en = drive_q & reset_b_w;
  assign cfg_valid    = cfg_valid_q;
  assign dip_cfg      = dip_cfg_q;
  assign ramblock     = ramblock_q;
  assign mode3_od     = mode3_od_q;
  assign urom_dis     = urom_dis_q;
  assign lrom_dis     = lrom_dis_q;
  assign cfg_wr       = cfg_wr_q;

endmodule
